// File: rtl/axil_write_queued_pkg.sv
// rtl/axil_write_queued_pkg.sv - shared types and constants for the queued AXI-Lite write master
// Contents: one-hot FSM state type, BRESP codes, queue-level width helper.
package axil_write_queued_pkg;

  // One-hot encoding keeps the state decode to a single bit per state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_RESP  = 3'b100
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Occupancy needs one extra bit so that a completely full queue (DEPTH) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axil_write_queued_if.sv
// rtl/axil_write_queued_if.sv - config, AXI-Lite write and status signals of the write master
// master modport: the write master (consumes cfg commands, drives AW/W, accepts B, reports status)
// slave modport : the environment (issues cfg commands, answers AW/W/B, observes status)
interface axil_write_queued_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              s_axi_cfg_wvalid;
  logic [ADDR_W-1:0] s_axi_cfg_waddr;
  logic [DATA_W-1:0] s_axi_cfg_wdata;
  logic [STRB_W-1:0] s_axi_cfg_wstrb;
  logic              s_axi_cfg_wready;

  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [2:0]        s_axi_awprot;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0] s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic              s_axi_bvalid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bready;

  logic              sts_valid;
  logic [1:0]        sts_resp;
  logic              err_timeout;
  logic              busy;
  logic [LVL_W-1:0]  q_level;

  modport master (
    input  s_axi_cfg_wvalid, s_axi_cfg_waddr, s_axi_cfg_wdata, s_axi_cfg_wstrb,
    output s_axi_cfg_wready,
    output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bvalid, s_axi_bresp,
    output s_axi_bready,
    output sts_valid, sts_resp, err_timeout, busy, q_level
  );

  modport slave (
    output s_axi_cfg_wvalid, s_axi_cfg_waddr, s_axi_cfg_wdata, s_axi_cfg_wstrb,
    input  s_axi_cfg_wready,
    input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bvalid, s_axi_bresp,
    input  s_axi_bready,
    input  sts_valid, sts_resp, err_timeout, busy, q_level
  );

endinterface

// File: rtl/axil_write_queued_cmd_fifo.sv
// rtl/axil_write_queued_cmd_fifo.sv - synchronous command FIFO with occupancy output
// clk, rst_n       : clock, async active-low reset
// push, push_data  : write an entry (ignored when full)
// pop, pop_data    : pop_data always shows the oldest entry; pop removes it (ignored when empty)
// full, empty      : status
// level            : number of stored entries, 0..DEPTH
module axil_write_queued_cmd_fifo
  import axil_write_queued_pkg::*;
#(
  parameter int W     = 68,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [W-1:0]            push_data,
  input  logic                    pop,
  output logic [W-1:0]            pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  // Output comes straight from the storage registers, so no input-to-output path exists.
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (!do_push && do_pop) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/axil_write_queued.sv
// rtl/axil_write_queued.sv - queued AXI4-Lite write master with per-command BRESP and watchdog
// s_axi_aclk    : clock
// s_axi_aresetn : async active-low reset; discards queued and in-flight commands
// bus (master)  : cfg command port (valid/addr/data/strb/ready), AXI-Lite AW/W/B,
//                 status (sts_valid/sts_resp/err_timeout/busy/q_level)
module axil_write_queued
  import axil_write_queued_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  axil_write_queued_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CMD_W  = ADDR_W + DATA_W + STRB_W;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state;
  state_e            state_nxt;

  logic [CMD_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [STRB_W-1:0] cmd_strb;

  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              sts_valid_q;
  logic [1:0]        sts_resp_q;
  logic              err_q;
  logic [CNT_W-1:0]  wd_cnt;

  logic              aw_pending;
  logic              w_pending;
  logic              b_done;

  assign fifo_push = bus.s_axi_cfg_wvalid & ~fifo_full;
  assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;
  assign {cmd_addr, cmd_data, cmd_strb} = fifo_rdata;

  axil_write_queued_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .push      (fifo_push),
    .push_data ({bus.s_axi_cfg_waddr, bus.s_axi_cfg_wdata, bus.s_axi_cfg_wstrb}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (bus.q_level)
  );

  // A channel is still pending if its valid is up and the slave has not taken it this cycle.
  assign aw_pending = awvalid_q & ~bus.s_axi_awready;
  assign w_pending  = wvalid_q & ~bus.s_axi_wready;
  assign b_done     = bready_q & bus.s_axi_bvalid;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!fifo_empty)               state_nxt = ST_ISSUE;
      ST_ISSUE: if (!aw_pending && !w_pending) state_nxt = ST_RESP;
      ST_RESP:  if (b_done)                    state_nxt = ST_IDLE;
      default:                                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      sts_valid_q <= 1'b0;
      sts_resp_q  <= RESP_OKAY;
    end else begin
      sts_valid_q <= 1'b0;
      if (state == ST_IDLE && !fifo_empty) begin
        awaddr_q  <= cmd_addr;
        wdata_q   <= cmd_data;
        wstrb_q   <= cmd_strb;
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
      end
      if (state == ST_ISSUE) begin
        if (bus.s_axi_awready) awvalid_q <= 1'b0;
        if (bus.s_axi_wready)  wvalid_q  <= 1'b0;
        if (!aw_pending && !w_pending) bready_q <= 1'b1;
      end
      if (state == ST_RESP && b_done) begin
        bready_q    <= 1'b0;
        sts_valid_q <= 1'b1;
        sts_resp_q  <= bus.s_axi_bresp;
      end
    end
  end

  // Watchdog: counts cycles spent in ISSUE/RESP; the flag rises as the count reaches TIMEOUT
  // and is only informational. Completion clears it, taking priority over a coincident set.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE)                  wd_cnt <= '0;
      else if (wd_cnt != CNT_W'(TIMEOUT))    wd_cnt <= wd_cnt + CNT_W'(1);

      if (state == ST_RESP && b_done)
        err_q <= 1'b0;
      else if (TIMEOUT != 0 && state != ST_IDLE && wd_cnt == CNT_W'(TIMEOUT - 1))
        err_q <= 1'b1;
    end
  end

  assign bus.s_axi_cfg_wready = ~fifo_full;
  assign bus.s_axi_awaddr     = awaddr_q;
  assign bus.s_axi_awprot     = 3'b000;
  assign bus.s_axi_awvalid    = awvalid_q;
  assign bus.s_axi_wdata      = wdata_q;
  assign bus.s_axi_wstrb      = wstrb_q;
  assign bus.s_axi_wvalid     = wvalid_q;
  assign bus.s_axi_bready     = bready_q;
  assign bus.sts_valid        = sts_valid_q;
  assign bus.sts_resp         = sts_resp_q;
  assign bus.err_timeout      = err_q;
  assign bus.busy             = ~fifo_empty | (state != ST_IDLE);

endmodule

// File: tb/tb_axil_write_queued.sv
// tb/tb_axil_write_queued.sv - scoreboard bench for the queued AXI-Lite write master
module tb_axil_write_queued;
  import axil_write_queued_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_write_queued_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  axil_write_queued #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_resp[$];
  logic [1:0]  resp_plan[$];

  int aw_delay = 0;
  int w_delay  = 0;
  int b_delay  = 0;
  bit stall    = 1'b0;
  int aw_cnt   = 0;
  int w_cnt    = 0;
  int b_cnt    = 0;

  int aw_hs_n = 0, w_hs_n = 0, sts_n = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;
  logic        prev_awv = 1'b0, prev_wv = 1'b0, prev_aw_hs = 1'b0, prev_w_hs = 1'b0, prev_sts = 1'b0;
  logic [31:0] prev_awaddr = '0;
  logic [35:0] prev_w = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: inputs change on the falling edge only.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bus.s_axi_awready = 1'b0;
      bus.s_axi_wready  = 1'b0;
      bus.s_axi_bvalid  = 1'b0;
      bus.s_axi_bresp   = 2'b00;
      aw_cnt = 0;
      w_cnt  = 0;
      b_cnt  = 0;
    end else begin
      if (bus.s_axi_awvalid && !stall) begin
        bus.s_axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        bus.s_axi_awready = 1'b0;
        if (!bus.s_axi_awvalid) aw_cnt = 0;
      end
      if (bus.s_axi_wvalid && !stall) begin
        bus.s_axi_wready = (w_cnt >= w_delay);
        w_cnt++;
      end else begin
        bus.s_axi_wready = 1'b0;
        if (!bus.s_axi_wvalid) w_cnt = 0;
      end
      // bready only drops after a B handshake, so bvalid high with bready low means it was taken.
      if (bus.s_axi_bvalid && !bus.s_axi_bready) begin
        bus.s_axi_bvalid = 1'b0;
        b_cnt = 0;
      end else if (bus.s_axi_bready && !bus.s_axi_bvalid) begin
        if (b_cnt >= b_delay) begin
          bus.s_axi_bvalid = 1'b1;
          bus.s_axi_bresp  = (resp_plan.size() != 0) ? resp_plan.pop_front() : RESP_OKAY;
        end else begin
          b_cnt++;
        end
      end
    end
  end

  // Monitor: samples mid low phase, when everything the next rising edge will see is settled.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_awv = 1'b0; prev_wv = 1'b0; prev_aw_hs = 1'b0; prev_w_hs = 1'b0; prev_sts = 1'b0;
    end else begin
      if (prev_awv && !prev_aw_hs) begin
        chk("awvalid_hold", bus.s_axi_awvalid, 1);
        chk("awaddr_stable", bus.s_axi_awaddr, prev_awaddr);
      end
      if (prev_wv && !prev_w_hs) begin
        chk("wvalid_hold", bus.s_axi_wvalid, 1);
        chk("wdata_stable", {bus.s_axi_wdata, bus.s_axi_wstrb}, prev_w);
      end
      if (bus.s_axi_awvalid && bus.s_axi_awready) begin
        aw_hs_n++;
        aw_hs_cyc = cyc;
        if (exp_aw.size() == 0) fail("aw_unexpected");
        else chk("awaddr", bus.s_axi_awaddr, exp_aw.pop_front());
      end
      if (bus.s_axi_wvalid && bus.s_axi_wready) begin
        w_hs_n++;
        w_hs_cyc = cyc;
        if (exp_w.size() == 0) fail("w_unexpected");
        else chk("wdata_wstrb", {bus.s_axi_wdata, bus.s_axi_wstrb}, exp_w.pop_front());
      end
      if (bus.s_axi_bready && (bus.s_axi_awvalid || bus.s_axi_wvalid)) fail("bready_early");
      if (bus.sts_valid) begin
        sts_n++;
        if (prev_sts) fail("sts_valid_width");
        if (exp_resp.size() == 0) fail("sts_unexpected");
        else chk("sts_resp", bus.sts_resp, exp_resp.pop_front());
      end
      prev_awv    = bus.s_axi_awvalid;
      prev_wv     = bus.s_axi_wvalid;
      prev_aw_hs  = bus.s_axi_awvalid & bus.s_axi_awready;
      prev_w_hs   = bus.s_axi_wvalid & bus.s_axi_wready;
      prev_sts    = bus.sts_valid;
      prev_awaddr = bus.s_axi_awaddr;
      prev_w      = {bus.s_axi_wdata, bus.s_axi_wstrb};
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.s_axi_cfg_wvalid = 1'b1;
    bus.s_axi_cfg_waddr  = a;
    bus.s_axi_cfg_wdata  = d;
    bus.s_axi_cfg_wstrb  = s;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.s_axi_cfg_wready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail("push_timeout");
    end else begin
      exp_aw.push_back(a);
      exp_w.push_back({d, s});
      exp_resp.push_back(r);
      resp_plan.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.s_axi_cfg_wvalid = 1'b0;
  endtask

  task automatic wait_idle(input int cap);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < cap; i++) begin
      @(negedge clk);
      #2;
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("wait_idle_timeout");
    @(negedge clk);
  endtask

  initial begin
    int s0, a0, w0, k;
    bit seen;
    bus.s_axi_cfg_wvalid = 1'b0;
    bus.s_axi_cfg_waddr  = '0;
    bus.s_axi_cfg_wdata  = '0;
    bus.s_axi_cfg_wstrb  = '0;
    bus.s_axi_awready    = 1'b0;
    bus.s_axi_wready     = 1'b0;
    bus.s_axi_bvalid     = 1'b0;
    bus.s_axi_bresp      = 2'b00;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_awvalid", bus.s_axi_awvalid, 0);
    chk("rst_wvalid", bus.s_axi_wvalid, 0);
    chk("rst_bready", bus.s_axi_bready, 0);
    chk("rst_sts_valid", bus.sts_valid, 0);
    chk("rst_sts_resp", bus.sts_resp, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_q_level", bus.q_level, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cfg_wready", bus.s_axi_cfg_wready, 1);
    chk("awprot", bus.s_axi_awprot, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single write, latency N+2
    s0 = sts_n;
    push(32'h10, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    @(negedge clk); #2;
    chk("t1_awvalid_n1", bus.s_axi_awvalid, 0);
    chk("t1_q_level_n1", bus.q_level, 1);
    @(negedge clk); #2;
    chk("t1_awvalid_n2", bus.s_axi_awvalid, 1);
    chk("t1_wvalid_n2", bus.s_axi_wvalid, 1);
    chk("t1_q_level_n2", bus.q_level, 0);
    wait_idle(100);
    chk("t1_sts_count", sts_n - s0, 1);

    // 2: AW accepted three cycles before W
    w_delay = 3;
    s0 = sts_n; a0 = aw_hs_n; w0 = w_hs_n;
    push(32'h20, 32'h12345678, 4'h3, RESP_OKAY);
    wait_idle(100);
    chk("t2_aw_hs", aw_hs_n - a0, 1);
    chk("t2_w_hs", w_hs_n - w0, 1);
    chk("t2_w_after_aw", w_hs_cyc - aw_hs_cyc, 3);
    chk("t2_sts_count", sts_n - s0, 1);
    w_delay = 0;

    // 3: queue fills behind a stalled command
    stall = 1'b1;
    s0 = sts_n;
    push(32'h100, 32'h0000_0001, 4'hF, RESP_OKAY);
    repeat (2) @(negedge clk);
    push(32'h104, 32'h0000_0002, 4'h1, RESP_OKAY);
    push(32'h108, 32'h0000_0003, 4'h2, RESP_OKAY);
    push(32'h10C, 32'h0000_0004, 4'h4, RESP_OKAY);
    push(32'h110, 32'h0000_0005, 4'h8, RESP_OKAY);
    @(negedge clk); #2;
    chk("t3_q_level_full", bus.q_level, 4);
    chk("t3_cfg_wready_full", bus.s_axi_cfg_wready, 0);
    chk("t3_busy", bus.busy, 1);
    fork
      push(32'h114, 32'h0000_0006, 4'hC, RESP_OKAY);
      begin
        repeat (5) @(negedge clk);
        stall = 1'b0;
      end
    join
    wait_idle(500);
    chk("t3_q_level_empty", bus.q_level, 0);
    chk("t3_sts_count", sts_n - s0, 6);

    // 4: SLVERR on the middle write
    s0 = sts_n;
    push(32'h200, 32'hA5A5A5A5, 4'hF, RESP_OKAY);
    push(32'h204, 32'h5A5A5A5A, 4'hF, RESP_SLVERR);
    push(32'h208, 32'h0F0F0F0F, 4'hF, RESP_OKAY);
    wait_idle(200);
    chk("t4_sts_count", sts_n - s0, 3);
    chk("t4_sts_resp_held", bus.sts_resp, RESP_OKAY);

    // 5: watchdog with a slow B channel
    b_delay = 40;
    chk("t5_err_before", bus.err_timeout, 0);
    push(32'h40, 32'hCAFEF00D, 4'hF, RESP_OKAY);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (bus.s_axi_awvalid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail("t5_awvalid_timeout");
    for (k = 2; k <= 17; k++) begin
      @(negedge clk); #2;
      if (k == 16) chk("t5_err_cycle16", bus.err_timeout, 0);
      if (k == 17) chk("t5_err_cycle17", bus.err_timeout, 1);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (bus.sts_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.err_timeout !== 1'b1) begin
        fail("t5_err_not_sticky");
        break;
      end
    end
    if (!seen) fail("t5_sts_timeout");
    chk("t5_err_cleared", bus.err_timeout, 0);
    b_delay = 0;
    wait_idle(100);

    // 6: reset during ISSUE with two commands queued
    stall = 1'b1;
    push(32'h60, 32'h11111111, 4'hF, RESP_OKAY);
    push(32'h64, 32'h22222222, 4'hF, RESP_OKAY);
    push(32'h68, 32'h33333333, 4'hF, RESP_OKAY);
    @(negedge clk); #2;
    chk("t6_q_level_pre", bus.q_level, 2);
    chk("t6_awvalid_pre", bus.s_axi_awvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_awvalid_rst", bus.s_axi_awvalid, 0);
    chk("t6_wvalid_rst", bus.s_axi_wvalid, 0);
    chk("t6_q_level_rst", bus.q_level, 0);
    chk("t6_busy_rst", bus.busy, 0);
    exp_aw.delete();
    exp_w.delete();
    exp_resp.delete();
    resp_plan.delete();
    s0 = sts_n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    chk("t6_no_sts", sts_n - s0, 0);
    chk("t6_q_level_post", bus.q_level, 0);
    chk("t6_awvalid_post", bus.s_axi_awvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
